dmem_responder: RTL and testbench

//  Responder end of the dmem request/response interface driven by the memory unit.

---
 rtl/dmem_responder_if.sv | 27 ++
 rtl/dmem_responder.sv | 154 +++++++++++++++
 tb/tb_dmem_responder.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// dmem_responder_if
//   Request/response bundle between the memory unit (master) and the data
//   memory responder (slave).
//   addr   : byte address of the access, bits [1:0] ignored by the responder
//   rmask  : read byte-lane mask, nonzero marks a read request
//   wmask  : write byte-lane mask, nonzero marks a write request
//   wdata  : write data, lane-aligned to wmask
//   rdata  : full read word, valid while resp is high
//   resp   : one-cycle response pulse
interface dmem_responder_if;
   logic [31:0] addr;
   logic [3:0]  rmask;
   logic [3:0]  wmask;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        resp;

   modport master (
      output addr, rmask, wmask, wdata,
      input  rdata, resp
   );

   modport slave (
      input  addr, rmask, wmask, wdata,
      output rdata, resp
   );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
//   Responder end of the dmem request/response interface. Backs a
//   word-addressed SRAM of 2**DEPTH_LOG2 words located at BASE_ADDR, answers
//   each accepted request after a fixed latency and applies byte-masked writes.
//   Out-of-range accesses are answered with zero data and an oob pulse; their
//   writes are dropped.
// Ports
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset (the SRAM contents are not reset)
//   bus   : dmem_responder_if.slave (addr, rmask, wmask, wdata, rdata, resp)
//   busy  : high from acceptance of a request through its response cycle
//   oob   : one-cycle pulse alongside resp when the address was out of range
// Optional feature
//   DMEM_RAND_LATENCY_EN : when defined, an 8-bit Galois LFSR (taps 8,6,5,4,
//   seed 8'h5A) adds 0..3 cycles of extra latency to every accepted request.
module dmem_responder #(
   parameter int          DEPTH_LOG2 = 10,
   parameter logic [31:0] BASE_ADDR  = 32'haaaa_a000,
   parameter int          LATENCY    = 2
) (
   input  logic             clk,
   input  logic             rst,
   dmem_responder_if.slave  bus,
   output logic             busy,
   output logic             oob
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t                state;
   logic [4:0]            counter;
   logic [31:0]           cap_addr;
   logic [31:0]           cap_wdata;
   logic [3:0]            cap_wmask;
   logic [31:0]           rdata_q;
   logic                  resp_q;

   logic [31:0]           mem [DEPTH];

   logic                  req;
   logic [31:0]           offset;
   logic [31:0]           word_off;
   logic                  in_range;
   logic [DEPTH_LOG2-1:0] idx;
   logic                  wait_done;
   logic                  mem_we;
   logic [4:0]            load_count;

   assign req = (|bus.rmask) | (|bus.wmask);

   // The subtraction wraps for addresses below the base; the explicit
   // comparison catches that case so a wrapped offset is never in range.
   assign offset   = cap_addr - BASE_ADDR;
   assign word_off = offset >> 2;
   assign in_range = (cap_addr >= BASE_ADDR) && ((word_off >> DEPTH_LOG2) == 32'd0);
   assign idx      = word_off[DEPTH_LOG2-1:0];

   // Leaving WAIT when the counter is about to reach zero puts the response
   // in cycle T+LATENCY for LATENCY >= 2. A load value of zero (LATENCY=1)
   // still spends one cycle in WAIT.
   assign wait_done = (state == WAIT) && (counter <= 5'd1);
   assign mem_we    = wait_done && (|cap_wmask) && in_range;

`ifdef DMEM_RAND_LATENCY_EN
   logic [7:0] lfsr;

   // Right-shifting Galois LFSR for x^8+x^6+x^5+x^4+1, stepped once per
   // accepted request; the pre-step value picks the extra latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr <= 8'h5A;
      end else if ((state == IDLE) && req) begin
         lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
      end
   end

   assign load_count = 5'(LATENCY - 1) + {3'b000, lfsr[1:0]};
`else
   assign load_count = 5'(LATENCY - 1);
`endif

   // Request FSM. The request is captured in IDLE and the bus inputs are
   // ignored until the FSM is back in IDLE, so input churn in WAIT/RESP has
   // no effect. Read data is sampled at the RESP-entry edge, the same edge
   // that commits a write, so a write response returns the pre-write word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         counter   <= 5'd0;
         cap_addr  <= 32'd0;
         cap_wdata <= 32'd0;
         cap_wmask <= 4'd0;
         rdata_q   <= 32'd0;
         resp_q    <= 1'b0;
         busy      <= 1'b0;
         oob       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  cap_addr  <= bus.addr;
                  cap_wdata <= bus.wdata;
                  cap_wmask <= bus.wmask;
                  counter   <= load_count;
                  busy      <= 1'b1;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (wait_done) begin
                  counter <= 5'd0;
                  resp_q  <= 1'b1;
                  oob     <= ~in_range;
                  rdata_q <= in_range ? mem[idx] : 32'd0;
                  state   <= RESP;
               end else begin
                  counter <= counter - 5'd1;
               end
            end
            RESP: begin
               resp_q <= 1'b0;
               oob    <= 1'b0;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // SRAM write port, kept out of the reset domain so the array maps onto a
   // plain memory. Reset clears the FSM first, so a pending write never lands.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (cap_wmask[i]) begin
               mem[idx][8*i +: 8] <= cap_wdata[8*i +: 8];
            end
         end
      end
   end

   assign bus.rdata = rdata_q;
   assign bus.resp  = resp_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Self-checking bench for dmem_responder: directed cases for reset, full and
//   partial writes, out-of-range accesses and mid-operation reset, followed by
//   randomized requests with input churn checked against an array model.
module tb_dmem_responder;

   localparam int          DEPTH_LOG2 = 10;
   localparam int          DEPTH      = 1 << DEPTH_LOG2;
   localparam logic [31:0] BASE       = 32'haaaa_a000;
   localparam int          LATENCY    = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic busy;
   logic oob;

   dmem_responder_if bus();

   dmem_responder #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .BASE_ADDR  (BASE),
      .LATENCY    (LATENCY)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus.slave),
      .busy (busy),
      .oob  (oob)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference memory: word index -> value, only for words whose full
   // contents are known.
   logic [31:0] refMem [longint];

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // Issues one request in the current cycle, waits (bounded) for its
   // response, and compares it with the model. Masks stay held through the
   // response cycle, as the memory unit does.
   task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] rmask,
                                input logic [3:0] wmask, input logic [31:0] wdata,
                                input bit churn);
      bit          expOob;
      bit          dataKnown;
      logic [31:0] expData;
      longint      idx;
      int          lat;

      expOob    = 1'b0;
      dataKnown = 1'b1;
      expData   = 32'd0;
      idx       = 0;
      if (addr < BASE) begin
         expOob = 1'b1;
      end else begin
         idx = longint'(addr - BASE) / 4;
         if (idx >= DEPTH) expOob = 1'b1;
      end

      if (!expOob) begin
         if (refMem.exists(idx)) expData = refMem[idx];
         else dataKnown = 1'b0;
         if (wmask != 4'd0) begin
            if (refMem.exists(idx)) begin
               for (int i = 0; i < 4; i++)
                  if (wmask[i]) refMem[idx][8*i +: 8] = wdata[8*i +: 8];
            end else if (wmask == 4'hF) begin
               refMem[idx] = wdata;
            end
         end
      end

      @(negedge clk);
      checkOutput("noExtraResp", {31'd0, bus.resp}, 32'd0);
      bus.addr  = addr;
      bus.rmask = rmask;
      bus.wmask = wmask;
      bus.wdata = wdata;

      lat = 0;
      for (int k = 1; k <= 24 && lat == 0; k++) begin
         @(negedge clk);
         if (bus.resp) begin
            lat = k;
         end else begin
            checkOutput("busyInWait", {31'd0, busy}, 32'd1);
            checkOutput("oobInWait", {31'd0, oob}, 32'd0);
            if (churn) begin
               bus.addr  = $urandom;
               bus.rmask = 4'($urandom);
               bus.wmask = 4'($urandom);
               bus.wdata = $urandom;
            end
         end
      end

      if (lat == 0) begin
         checkOutput("respTimeout", 32'd0, 32'd1);
      end else begin
`ifdef DMEM_RAND_LATENCY_EN
         checkOutput("latencyRange", {31'd0, (lat >= LATENCY && lat <= LATENCY + 3)}, 32'd1);
`else
         checkOutput("latency", lat, LATENCY);
`endif
         checkOutput("oobFlag", {31'd0, oob}, {31'd0, expOob});
         checkOutput("busyInResp", {31'd0, busy}, 32'd1);
         if (dataKnown) checkOutput("rdata", bus.rdata, expData);
      end
   endtask

   task automatic goIdle();
      @(negedge clk);
      bus.rmask = 4'd0;
      bus.wmask = 4'd0;
   endtask

   initial begin
      logic [31:0] addr;
      logic [3:0]  rm;
      logic [3:0]  wm;
      logic [31:0] oobList [6];
      longint      pool [16];

      bus.addr  = 32'd0;
      bus.rmask = 4'd0;
      bus.wmask = 4'd0;
      bus.wdata = 32'd0;

      // Asynchronous reset asserted away from any clock edge.
      #2 rst = 1'b1;
      #1;
      checkOutput("rstResp", {31'd0, bus.resp}, 32'd0);
      checkOutput("rstBusy", {31'd0, busy}, 32'd0);
      checkOutput("rstRdata", bus.rdata, 32'd0);
      checkOutput("rstOob", {31'd0, oob}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Full write then readback.
      applyStimulus(BASE + 32'h10, 4'h0, 4'hF, 32'hDEADBEEF, 1'b0);
      applyStimulus(BASE + 32'h10, 4'hF, 4'h0, 32'h0, 1'b0);

      // Partial write on the upper half of the word.
      applyStimulus(BASE + 32'h10, 4'h0, 4'hF, 32'h11223344, 1'b0);
      applyStimulus(BASE + 32'h12, 4'h0, 4'hC, 32'hAABB0000, 1'b0);
      applyStimulus(BASE + 32'h10, 4'hF, 4'h0, 32'h0, 1'b0);

      // Out-of-range write below the base and read just past the top.
      applyStimulus(BASE - 32'd4, 4'h0, 4'hF, 32'hCAFEF00D, 1'b0);
      applyStimulus(BASE + (32'd4 << DEPTH_LOG2), 4'hF, 4'h0, 32'h0, 1'b0);

      // Topmost in-range word.
      applyStimulus(BASE + 32'(4 * (DEPTH - 1)), 4'h0, 4'hF, 32'h0BAD_F00D, 1'b0);
      applyStimulus(BASE + 32'(4 * (DEPTH - 1)), 4'hF, 4'h0, 32'h0, 1'b0);
      applyStimulus(BASE + 32'h10, 4'hF, 4'h0, 32'h0, 1'b0);

      // Reset during WAIT of a write: no response, write discarded, rdata
      // cleared immediately.
      @(negedge clk);
      bus.addr  = BASE + 32'h10;
      bus.rmask = 4'h0;
      bus.wmask = 4'hF;
      bus.wdata = 32'h5555_5555;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("midRstResp", {31'd0, bus.resp}, 32'd0);
      checkOutput("midRstBusy", {31'd0, busy}, 32'd0);
      checkOutput("midRstRdata", bus.rdata, 32'd0);
      bus.wmask = 4'h0;
      #1 rst = 1'b0;
      applyStimulus(BASE + 32'h10, 4'hF, 4'h0, 32'h0, 1'b0);

      // Random phase: pool of low and high words plus out-of-range addresses.
      for (int i = 0; i < 8; i++) begin
         pool[i]     = i;
         pool[i + 8] = DEPTH - 8 + i;
      end
      oobList[0] = BASE - 32'd4;
      oobList[1] = BASE - 32'd1;
      oobList[2] = 32'h0000_0000;
      oobList[3] = 32'hFFFF_FFFC;
      oobList[4] = BASE + 32'(4 * DEPTH);
      oobList[5] = BASE + 32'(4 * DEPTH) + 32'h200;

      for (int i = 0; i < 16; i++)
         applyStimulus(BASE + 32'(pool[i] * 4), 4'h0, 4'hF, $urandom, 1'b0);

      for (int n = 0; n < 256; n++) begin
         if ($urandom_range(0, 9) == 0)
            addr = oobList[$urandom_range(0, 5)];
         else
            addr = BASE + 32'(pool[$urandom_range(0, 15)] * 4) + 32'($urandom_range(0, 3));
         rm = 4'($urandom);
         wm = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         if (rm == 4'h0 && wm == 4'h0) rm = 4'hF;
         applyStimulus(addr, rm, wm, $urandom, 1'($urandom_range(0, 1)));
      end

      goIdle();
      @(negedge clk);
      checkOutput("finalIdleResp", {31'd0, bus.resp}, 32'd0);
      checkOutput("finalIdleBusy", {31'd0, busy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
